// File: rtl/ks_adder_pkg.sv
// ks_adder_pkg: shared op encoding, prefix-depth helper and per-rank sideband for ks_adder_pipe
package ks_adder_pkg;
  typedef enum logic {KS_ADD = 1'b0, KS_SUB = 1'b1} ks_op_e;
  typedef struct packed {
    logic cin;
    logic a_msb;
    logic b_msb;
    logic sat;
  } ks_side_t;
  function automatic int ks_levels(input int width);
    int l;
    l = 0;
    while ((1 << l) < width) l++;
    return l;
  endfunction
endpackage

// File: rtl/ks_gp_cell.sv
// ks_gp_cell: one Kogge-Stone black cell combining a high (G,P) pair with a lower one
module ks_gp_cell (
  input  logic g_hi,
  input  logic p_hi,
  input  logic g_lo,
  input  logic p_lo,
  output logic g,
  output logic p
);
  assign g = g_hi | (p_hi & g_lo);
  assign p = p_hi & p_lo;
endmodule

// File: rtl/ks_adder_pipe.sv
// ks_adder_pipe: pipelined Kogge-Stone add/sub with valid/ready stall; KS_ADDER_SAT_EN adds the sat clamp input
module ks_adder_pipe
  import ks_adder_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
`ifdef KS_ADDER_SAT_EN
  input  logic             sat,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             c0,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             ovf
);
  localparam int LEVELS  = ks_levels(WIDTH);
  localparam int LATENCY = LEVELS + 2;
  ks_op_e           op;
  logic [WIDTH-1:0] b0, g0, p0, carry, sum, res;
  logic             cin0, ov;
  ks_side_t         sd0;
  logic [LATENCY-1:0] vld;
  logic [WIDTH-1:0] gr [LEVELS+1];
  logic [WIDTH-1:0] pr [LEVELS+1];
  logic [WIDTH-1:0] por [LEVELS+1];
  logic [WIDTH-1:0] gn [1:LEVELS];
  logic [WIDTH-1:0] pn [1:LEVELS];
  ks_side_t         sr [LEVELS+1];
  assign op        = ks_op_e'(sub);
  assign out_valid = vld[LATENCY-1];
  assign in_ready  = !out_valid || out_ready;
  assign b0        = op == KS_SUB ? ~in2 : in2;
  assign cin0      = op == KS_SUB ? ~c0 : c0;
  assign p0        = in1 ^ b0;
  assign g0        = (in1 & b0) | {{(WIDTH-1){1'b0}}, p0[0] & cin0};
`ifdef KS_ADDER_SAT_EN
  assign sd0 = '{cin: cin0, a_msb: in1[WIDTH-1], b_msb: b0[WIDTH-1], sat: sat};
`else
  assign sd0 = '{cin: cin0, a_msb: in1[WIDTH-1], b_msb: b0[WIDTH-1], sat: 1'b0};
`endif
  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (i >= (1 << (k - 1))) begin : g_blk
        ks_gp_cell u_cell (
          .g_hi(gr[k-1][i]),
          .p_hi(pr[k-1][i]),
          .g_lo(gr[k-1][i-(1<<(k-1))]),
          .p_lo(pr[k-1][i-(1<<(k-1))]),
          .g   (gn[k][i]),
          .p   (pn[k][i])
        );
      end else begin : g_pass
        assign gn[k][i] = gr[k-1][i];
        assign pn[k][i] = pr[k-1][i];
      end
    end
  end
  // after the last level gr holds the carry out of every bit, cin already folded in
  assign carry = {gr[LEVELS][WIDTH-2:0], sr[LEVELS].cin};
  assign sum   = por[LEVELS] ^ carry;
  assign ov    = sr[LEVELS].a_msb == sr[LEVELS].b_msb && sum[WIDTH-1] != sr[LEVELS].a_msb;
`ifdef KS_ADDER_SAT_EN
  assign res = sr[LEVELS].sat && ov ? {sr[LEVELS].a_msb, {(WIDTH-1){!sr[LEVELS].a_msb}}} : sum;
`else
  assign res = sum;
`endif
  always_ff @(posedge clk)
    if (rst) begin
      vld  <= '0;
      out  <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
    end else if (in_ready) begin
      vld    <= {vld[LATENCY-2:0], in_valid};
      gr[0]  <= g0;
      pr[0]  <= p0;
      por[0] <= p0;
      sr[0]  <= sd0;
      for (int k = 1; k <= LEVELS; k++) begin
        gr[k]  <= gn[k];
        pr[k]  <= pn[k];
        por[k] <= por[k-1];
        sr[k]  <= sr[k-1];
      end
      out  <= res;
      cout <= gr[LEVELS][WIDTH-1];
      ovf  <= ov;
    end
endmodule

// File: tb/tb_ks_adder_pipe.sv
// tb_ks_adder_pipe: random and directed checks of ks_adder_pipe at WIDTH=32 and WIDTH=13 against an arithmetic model
module tb_ks_adder_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic        v32 = 0, r32, c32 = 0, s32 = 0, st32 = 0, ordy32 = 0, ov32, co32, of32;
  logic [31:0] a32 = 0, b32 = 0, o32;
  logic        v13 = 0, r13, c13 = 0, s13 = 0, st13 = 0, ordy13 = 0, ov13, co13, of13;
  logic [12:0] a13 = 0, b13 = 0, o13;
  int n_cmp = 0, n_bad = 0, pops32 = 0, pops13 = 0;
  longint unsigned q32[$], q13[$];
  logic [31:0] corners32 [4] = '{32'h0, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000};
  logic [12:0] corners13 [4] = '{13'h0, 13'h1FFF, 13'h0FFF, 13'h1000};

  always #5 clk = ~clk;

  ks_adder_pipe #(.WIDTH(32)) u32 (
    .clk(clk), .rst(rst),
`ifdef KS_ADDER_SAT_EN
    .sat(st32),
`endif
    .in_valid(v32), .in_ready(r32), .in1(a32), .in2(b32), .c0(c32), .sub(s32),
    .out_valid(ov32), .out_ready(ordy32), .out(o32), .cout(co32), .ovf(of32)
  );

  ks_adder_pipe #(.WIDTH(13)) u13 (
    .clk(clk), .rst(rst),
`ifdef KS_ADDER_SAT_EN
    .sat(st13),
`endif
    .in_valid(v13), .in_ready(r13), .in1(a13), .in2(b13), .c0(c13), .sub(s13),
    .out_valid(ov13), .out_ready(ordy13), .out(o13), .cout(co13), .ovf(of13)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // result packed as {ovf, cout, out[w-1:0]}
  function automatic longint unsigned model(input int w, input longint unsigned a, input longint unsigned b,
                                            input bit c, input bit s, input bit st);
    longint unsigned m, am, bb, full, r;
    longint sa, sb, sum, hi, lo;
    bit ovf;
    m    = (64'd1 << w) - 1;
    am   = a & m;
    bb   = s ? ~b & m : b & m;
    full = am + bb + 64'(c ^ s);
    r    = full & m;
    sa   = am[w-1] ? longint'(am) - longint'(64'd1 << w) : longint'(am);
    sb   = bb[w-1] ? longint'(bb) - longint'(64'd1 << w) : longint'(bb);
    sum  = sa + sb + longint'(c ^ s);
    hi   = longint'((64'd1 << (w - 1)) - 1);
    lo   = -hi - 1;
    ovf  = sum > hi || sum < lo;
    if (st && ovf) r = sum > hi ? 64'(hi) : 64'(lo) & m;
    return (64'(ovf) << (w + 1)) | (((full >> w) & 64'd1) << w) | r;
  endfunction

  function automatic logic [31:0] rnd32();
    return $urandom_range(0, 3) == 0 ? corners32[$urandom_range(0, 3)] : 32'($urandom);
  endfunction

  function automatic logic [12:0] rnd13();
    return $urandom_range(0, 3) == 0 ? corners13[$urandom_range(0, 3)] : 13'($urandom);
  endfunction

  always @(negedge clk)
    if (rst) q32.delete();
    else begin
      if (ov32 && ordy32) begin
        if (q32.size() == 0) check("d32_spurious", 64'(ov32), 64'd0);
        else begin
          check("d32_result", 64'({of32, co32, o32}), q32[0]);
          void'(q32.pop_front());
          pops32++;
        end
      end else if (ov32 && q32.size() != 0) check("d32_hold", 64'({of32, co32, o32}), q32[0]);
      if (v32 && r32) q32.push_back(model(32, 64'(a32), 64'(b32), c32, s32, st32));
    end

  always @(negedge clk)
    if (rst) q13.delete();
    else begin
      if (ov13 && ordy13) begin
        if (q13.size() == 0) check("d13_spurious", 64'(ov13), 64'd0);
        else begin
          check("d13_result", 64'({of13, co13, o13}), q13[0]);
          void'(q13.pop_front());
          pops13++;
        end
      end else if (ov13 && q13.size() != 0) check("d13_hold", 64'({of13, co13, o13}), q13[0]);
      if (v13 && r13) q13.push_back(model(13, 64'(a13), 64'(b13), c13, s13, st13));
    end

  task automatic send32(input logic [31:0] a, input logic [31:0] b, input logic c, input logic s, input logic st);
    int t = 0;
    v32 = 1; a32 = a; b32 = b; c32 = c; s32 = s; st32 = st;
    @(negedge clk);
    while (!r32 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t == 50) check("send32_timeout", 64'(t), 64'd0);
    @(posedge clk); #1;
    v32 = 0;
  endtask

  task automatic run32(input string tag, input logic [31:0] a, input logic [31:0] b, input logic c,
                       input logic s, input logic st, input logic [33:0] exp);
    int n = 1;
    send32(a, b, c, s, st);
    while (!ov32 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'd7);
    check(tag, 64'({of32, co32, o32}), 64'(exp));
    @(posedge clk); #1;
  endtask

  task automatic drain32(input string tag);
    int t = 0;
    while (q32.size() != 0 && t < 60) begin
      @(posedge clk); #1;
      t++;
    end
    check(tag, 64'(q32.size()), 64'd0);
  endtask

  initial begin
    int base, n, t;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("rst_in_ready", 64'(r32), 64'd1);
    check("rst_out_valid", 64'(ov32), 64'd0);
    check("rst_out", 64'({of32, co32, o32}), 64'd0);
    check("rst_out_valid13", 64'(ov13), 64'd0);
    @(posedge clk); #1;
    ordy32 = 1;
    run32("add_wrap", 32'hFFFFFFFF, 32'h1, 0, 0, 0, {1'b0, 1'b1, 32'h0});
    run32("sub_neg", 32'd5, 32'd7, 0, 0 | 1'b1, 0, {1'b0, 1'b0, 32'hFFFFFFFE});
    run32("add_ovf", 32'h7FFFFFFF, 32'h1, 0, 0, 0, {1'b1, 1'b0, 32'h80000000});
    run32("sub_borrow_in", 32'd10, 32'd3, 1, 1, 0, {1'b0, 1'b1, 32'd6});
`ifdef KS_ADDER_SAT_EN
    run32("sat_pos", 32'h7FFFFFFF, 32'h1, 0, 0, 1, {1'b1, 1'b0, 32'h7FFFFFFF});
    run32("sat_neg", 32'h80000000, 32'h1, 0, 1, 1, {1'b1, 1'b1, 32'h80000000});
`endif
    base = pops32;
    for (int i = 0; i < 100; i++) begin
      v32 = 1; a32 = rnd32(); b32 = rnd32(); c32 = 1'($urandom); s32 = 1'($urandom);
`ifdef KS_ADDER_SAT_EN
      st32 = 1'($urandom);
`endif
      @(negedge clk);
      check("b2b_in_ready", 64'(r32), 64'd1);
      @(posedge clk); #1;
    end
    v32 = 0; st32 = 0;
    drain32("b2b_drain");
    check("b2b_count", 64'(pops32 - base), 64'd100);
    ordy32 = 0;
    base = pops32;
    repeat (3) send32(rnd32(), rnd32(), 1'($urandom), 1'($urandom), 0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("bp_out_valid", 64'(ov32), 64'd1);
    check("bp_in_ready", 64'(r32), 64'd0);
    @(posedge clk); #1;
    ordy32 = 1;
    drain32("bp_drain");
    check("bp_count", 64'(pops32 - base), 64'd3);
    repeat (2) send32(rnd32(), rnd32(), 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("rst_flush", 64'(ov32), 64'd0);
    end
    @(posedge clk); #1;
    run32("post_rst", 32'h12345678, 32'h11111111, 0, 0, 0, {1'b0, 1'b0, 32'h23456789});
    ordy13 = 1;
    a13 = 13'h1FFF; b13 = 13'h1FFF; c13 = 1; s13 = 0; v13 = 1;
    @(posedge clk); #1;
    v13 = 0;
    n = 1;
    while (!ov13 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("w13_latency", 64'(n), 64'd6);
    check("w13_all_ones", 64'({of13, co13, o13}), 64'h3FFF);
    @(posedge clk); #1;
    base = pops13;
    for (int i = 0; i < 300; i++) begin
      ordy13 = $urandom_range(0, 3) != 0;
      v13 = 1'($urandom);
      a13 = rnd13(); b13 = rnd13(); c13 = 1'($urandom); s13 = 1'($urandom);
`ifdef KS_ADDER_SAT_EN
      st13 = 1'($urandom);
`endif
      @(posedge clk); #1;
    end
    v13 = 0; ordy13 = 1;
    t = 0;
    while (q13.size() != 0 && t < 60) begin
      @(posedge clk); #1;
      t++;
    end
    check("w13_drain", 64'(q13.size()), 64'd0);
    check("w13_some_results", 64'(pops13 - base > 50), 64'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end
endmodule
